// File: rtl/mux8_rr_collector_pkg.sv
// Shared constants for the 8-lane collector and its demux counterpart.
// Keeping the select width and lane slicing here keeps both sides' encodings identical.
package mux8_rr_collector_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    // LSB position of lane 'lane' inside a packed multi-lane data bus.
    function automatic int lane_lsb(input int lane, input int data_w);
        return lane * data_w;
    endfunction

endpackage

// File: rtl/mux8_rr_collector_rr_arbiter8.sv
// Combinational 8-way round-robin arbiter: scans ptr, ptr+1, ... (mod 8),
// and grants the first requesting lane when enabled.
module rr_arbiter8
    import mux8_rr_collector_pkg::*;
(
    input  logic [N_CH-1:0]  i_req,
    input  logic [SEL_W-1:0] i_ptr,
    input  logic             i_en,
    output logic [N_CH-1:0]  o_grant,
    output logic [SEL_W-1:0] o_grant_idx,
    output logic             o_grant_valid
);

    logic [SEL_W-1:0] w_scan;
    logic [SEL_W-1:0] w_idx;
    logic             w_found;
    logic [N_CH-1:0]  w_one;

    // Priority scan starting at the pointer; the 3-bit add gives the mod-8 wrap.
    always_comb begin
        w_scan  = 3'd0;
        w_idx   = 3'd0;
        w_found = 1'b0;
        w_one   = 8'h01;
        for (int k = 0; k < N_CH; k++) begin
            w_scan = i_ptr + k[SEL_W-1:0];
            if (!w_found && i_req[w_scan]) begin
                w_found = 1'b1;
                w_idx   = w_scan;
            end else begin
                w_found = w_found;
            end
        end
        o_grant_valid = i_en & w_found;
        o_grant_idx   = w_idx;
        if (o_grant_valid) begin
            o_grant = w_one << w_idx;
        end else begin
            o_grant = 8'h00;
        end
    end

endmodule

// File: rtl/mux8_rr_collector.sv
// 8-to-1 round-robin stream collector with a registered output beat that
// carries the source lane index for routing back through a 1x8 demux.
module mux8_rr_collector
    import mux8_rr_collector_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_CH-1:0]        i_in_valid,
    input  logic [N_CH*DATA_W-1:0] i_in_data,
    output logic [N_CH-1:0]        o_in_ready,
    output logic                   o_out_valid,
    output logic [DATA_W-1:0]      o_out_data,
    output logic [SEL_W-1:0]       o_out_sel,
    input  logic                   i_out_ready
);

    logic                r_valid;
    logic [DATA_W-1:0]   r_data;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_ptr;

    logic                w_load_en;
    logic                w_arb_en;
    logic [N_CH-1:0]     w_grant;
    logic [SEL_W-1:0]    w_grant_idx;
    logic                w_grant_valid;
    logic [DATA_W-1:0]   w_sel_data;

    // Reset is folded into the enable so no lane sees ready while rst is high.
    always_comb begin
        w_load_en = ~r_valid | i_out_ready;
        w_arb_en  = w_load_en & ~i_rst;
    end

    rr_arbiter8 u_arb (
        .i_req         (i_in_valid),
        .i_ptr         (r_ptr),
        .i_en          (w_arb_en),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    // Data select for the granted lane.
    always_comb begin
        w_sel_data = i_in_data[lane_lsb(int'(w_grant_idx), DATA_W) +: DATA_W];
    end

    // Output beat register and priority pointer; pointer moves only on a transfer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= 3'd0;
            r_ptr   <= 3'd0;
        end else if (w_grant_valid) begin
            r_valid <= 1'b1;
            r_data  <= w_sel_data;
            r_sel   <= w_grant_idx;
            r_ptr   <= w_grant_idx + 3'd1;
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_in_ready  = w_grant;
    assign o_out_valid = r_valid;
    assign o_out_data  = r_data;
    assign o_out_sel   = r_sel;

endmodule

// File: tb/tb_mux8_rr_collector.sv
// Directed bench for mux8_rr_collector: stimulus pushes expected beats into a
// queue, a negedge monitor pops and compares every beat accepted downstream.
module tb_mux8_rr_collector;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [7:0]    in_valid;
    logic [8*DW-1:0] in_data;
    logic [7:0]    in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [2:0]    out_sel;
    logic          out_ready;

    int n_cmp;
    int n_bad;
    logic [10:0] sb_q[$];

    mux8_rr_collector #(.DATA_W(DW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .o_out_sel   (out_sel),
        .i_out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_lane(input int i, input logic [7:0] d);
        in_data[i*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every beat consumed downstream must match the queue head.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_beat", {21'd0, out_sel, out_data}, 32'hFFFF_FFFF);
            end else begin
                logic [10:0] e;
                e = sb_q.pop_front();
                chk("beat_sel", {29'd0, out_sel}, {29'd0, e[10:8]});
                chk("beat_data", {24'd0, out_data}, {24'd0, e[7:0]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] one;
        one       = 8'h01;
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) set_lane(i, 8'(i + 16));

        // Reset held with all lanes valid.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_sel", {29'd0, out_sel}, 32'd0);
            chk("rst_out_data", {24'd0, out_data}, 32'd0);
            chk("rst_in_ready", {24'd0, in_ready}, 32'd0);
        end
        tick();
        rst      = 1'b0;
        in_valid = 8'h00;

        // Single lane 5.
        in_valid = 8'h20;
        set_lane(5, 8'hA5);
        @(negedge clk);
        chk("single_in_ready", {24'd0, in_ready}, 32'h20);
        sb_q.push_back({3'd5, 8'hA5});
        tick();
        in_valid = 8'h00;
        @(negedge clk);
        chk("single_out_valid", {31'd0, out_valid}, 32'd1);
        tick();

        // Reset pulse to bring ptr back to 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) set_lane(i, 8'(i + 16));

        // All lanes valid: grants 0..7,0 back to back.
        in_valid = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("rr_in_ready", {24'd0, in_ready}, {24'd0, one << (k % 8)});
            if (k > 0) chk("rr_no_bubble", {31'd0, out_valid}, 32'd1);
            sb_q.push_back({3'(k % 8), 8'(16 + (k % 8))});
            tick();
        end
        in_valid = 8'h00;
        tick();

        // Backpressure: ptr=1, accept lane 3, then stall 4 cycles.
        in_valid = 8'h08;
        set_lane(3, 8'h33);
        set_lane(4, 8'h44);
        @(negedge clk);
        chk("bp_in_ready", {24'd0, in_ready}, 32'h08);
        sb_q.push_back({3'd3, 8'h33});
        tick();
        in_valid  = 8'h18;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stall_in_ready", {24'd0, in_ready}, 32'd0);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_sel", {29'd0, out_sel}, 32'd3);
            chk("stall_data", {24'd0, out_data}, 32'h33);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {24'd0, in_ready}, 32'h10);
        sb_q.push_back({3'd4, 8'h44});
        tick();
        in_valid = 8'h00;

        // Wrap-around: lane 6 grant sets ptr=7, then lanes 7 and 2.
        in_valid = 8'h40;
        set_lane(6, 8'h66);
        set_lane(7, 8'h77);
        set_lane(2, 8'h22);
        @(negedge clk);
        chk("wrap6_in_ready", {24'd0, in_ready}, 32'h40);
        sb_q.push_back({3'd6, 8'h66});
        tick();
        in_valid = 8'h84;
        @(negedge clk);
        chk("wrap7_in_ready", {24'd0, in_ready}, 32'h80);
        sb_q.push_back({3'd7, 8'h77});
        tick();
        in_valid = 8'h04;
        @(negedge clk);
        chk("wrap2_in_ready", {24'd0, in_ready}, 32'h04);
        sb_q.push_back({3'd2, 8'h22});
        tick();
        // ptr=3: lanes 0 and 4 requesting -> lane 4 wins.
        in_valid = 8'h11;
        @(negedge clk);
        chk("ptr3_in_ready", {24'd0, in_ready}, 32'h10);
        sb_q.push_back({3'd4, 8'h44});
        tick();
        in_valid = 8'h00;

        // Reset mid-stream with a stalled lane-2 beat.
        for (int i = 0; i < 8; i++) set_lane(i, 8'(i + 16));
        in_valid = 8'h04;
        @(negedge clk);
        chk("pre_rst_in_ready", {24'd0, in_ready}, 32'h04);
        sb_q.push_back({3'd2, 8'h12});
        tick();
        in_valid  = 8'hFF;
        out_ready = 1'b0;
        @(negedge clk);
        chk("mid_stall_sel", {29'd0, out_sel}, 32'd2);
        chk("mid_stall_in_ready", {24'd0, in_ready}, 32'd0);
        tick();
        void'(sb_q.pop_back());
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", {24'd0, in_ready}, 32'd0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_in_ready", {24'd0, in_ready}, 32'h01);
        sb_q.push_back({3'd0, 8'h10});
        tick();
        in_valid = 8'h00;
        tick();
        tick();
        chk("queue_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
